// File: rtl/npu_host_dma.sv
// Host-side DMA for the NPU. It streams config and input words from memory into
// the NPU FIFOs and drains NPU results back to memory, one job per start pulse.
module npu_host_dma (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] cfg_base,
    input  logic [7:0]  cfg_count,
    input  logic [31:0] in_base,
    input  logic [15:0] in_count,
    input  logic [31:0] out_base,
    input  logic [15:0] out_count,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [25:0] npu_config_data,
    output logic        npu_config_fifo_write_enable,
    input  logic        npu_config_fifo_full,
    output logic [31:0] npu_input_data,
    output logic        npu_input_fifo_write_enable,
    input  logic        npu_input_fifo_full,
    input  logic [31:0] npu_output_data,
    input  logic        npu_output_fifo_empty,
    output logic        npu_output_fifo_read_enable
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CFG_RD   = 4'd1,
        CFG_PUSH = 4'd2,
        SEL      = 4'd3,
        IN_RD    = 4'd4,
        IN_PUSH  = 4'd5,
        OUT_POP  = 4'd6,
        OUT_CAP  = 4'd7,
        OUT_WR   = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t      state_r;
    logic [31:0] cfg_addr_r, in_addr_r, out_addr_r, hold_r;
    logic [7:0]  cfg_cnt_r;
    logic [15:0] in_cnt_r, out_cnt_r;
    logic        busy_r, done_r, mem_req_r, mem_we_r;
    logic [31:0] mem_addr_r, mem_wdata_r, in_data_r;
    logic [25:0] cfg_data_r;
    logic        cfg_we_r, in_we_r, out_re_r;

    assign busy                         = busy_r;
    assign done                         = done_r;
    assign mem_req                      = mem_req_r;
    assign mem_we                       = mem_we_r;
    assign mem_addr                     = mem_addr_r;
    assign mem_wdata                    = mem_wdata_r;
    assign npu_config_data              = cfg_data_r;
    assign npu_config_fifo_write_enable = cfg_we_r;
    assign npu_input_data               = in_data_r;
    assign npu_input_fifo_write_enable  = in_we_r;
    assign npu_output_fifo_read_enable  = out_re_r;

    // Job sequencer: every output is a register written only from this block.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= IDLE;
            cfg_addr_r  <= 32'd0;
            in_addr_r   <= 32'd0;
            out_addr_r  <= 32'd0;
            hold_r      <= 32'd0;
            cfg_cnt_r   <= 8'd0;
            in_cnt_r    <= 16'd0;
            out_cnt_r   <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            in_data_r   <= 32'd0;
            cfg_data_r  <= 26'd0;
            cfg_we_r    <= 1'b0;
            in_we_r     <= 1'b0;
            out_re_r    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            done_r   <= 1'b0;
            cfg_we_r <= 1'b0;
            in_we_r  <= 1'b0;
            out_re_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cfg_addr_r <= cfg_base;
                        in_addr_r  <= in_base;
                        out_addr_r <= out_base;
                        cfg_cnt_r  <= cfg_count;
                        in_cnt_r   <= in_count;
                        out_cnt_r  <= out_count;
                        busy_r     <= 1'b1;
                        state_r    <= (cfg_count != 8'd0) ? CFG_RD : SEL;
                    end
                end
                CFG_RD: begin
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= cfg_addr_r;
                    end else if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        hold_r    <= mem_rdata;
                        state_r   <= CFG_PUSH;
                    end
                end
                CFG_PUSH: begin
                    if (!npu_config_fifo_full) begin
                        cfg_we_r   <= 1'b1;
                        cfg_data_r <= hold_r[25:0];
                        cfg_addr_r <= cfg_addr_r + 32'd4;
                        if (cfg_cnt_r != 8'd0) begin
                            cfg_cnt_r <= cfg_cnt_r - 8'd1;
                        end
                        state_r <= (cfg_cnt_r > 8'd1) ? CFG_RD : SEL;
                    end
                end
                SEL: begin
                    // Results drain first so a full output FIFO cannot stall input pushes forever.
                    if ((out_cnt_r != 16'd0) && !npu_output_fifo_empty) begin
                        out_re_r <= 1'b1;
                        state_r  <= OUT_POP;
                    end else if (in_cnt_r != 16'd0) begin
                        state_r <= IN_RD;
                    end else if (out_cnt_r != 16'd0) begin
                        state_r <= SEL;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                IN_RD: begin
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= in_addr_r;
                    end else if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        hold_r    <= mem_rdata;
                        state_r   <= IN_PUSH;
                    end
                end
                IN_PUSH: begin
                    if (!npu_input_fifo_full) begin
                        in_we_r   <= 1'b1;
                        in_data_r <= hold_r;
                        in_addr_r <= in_addr_r + 32'd4;
                        if (in_cnt_r != 16'd0) begin
                            in_cnt_r <= in_cnt_r - 16'd1;
                        end
                        state_r <= SEL;
                    end
                end
                OUT_POP: begin
                    state_r <= OUT_CAP;
                end
                OUT_CAP: begin
                    hold_r  <= npu_output_data;
                    state_r <= OUT_WR;
                end
                OUT_WR: begin
                    if (!mem_req_r) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= out_addr_r;
                        mem_wdata_r <= hold_r;
                    end else if (mem_ack) begin
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        out_addr_r <= out_addr_r + 32'd4;
                        if (out_cnt_r != 16'd0) begin
                            out_cnt_r <= out_cnt_r - 16'd1;
                        end
                        state_r <= SEL;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
